// File: rtl/key_input_pkg.sv
// ============================================================================
// Module      : key_input_pkg
// Description : Shared types and default constants for the key_input block:
//               repeat-FSM state encoding, default cycle counts and a small
//               helper used to size the shared repeat counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_input_pkg;

    // Default channel count and timing (cycles of clk)
    localparam int unsigned c_NUM_KEYS_DEF     = 4;
    localparam int unsigned c_DEBOUNCE_CYC_DEF = 1000000;
    localparam int unsigned c_DAS_CYC_DEF      = 50000000;
    localparam int unsigned c_ARR_CYC_DEF      = 10000000;

    // Auto-repeat state per key
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Larger of two cycle limits; one counter serves both repeat phases
    function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : key_input_pkg

`default_nettype wire

// File: rtl/key_channel.sv
// ============================================================================
// Module      : key_channel
// Description : One key: 2-flop synchronizer, saturating debounce counter,
//               rising-edge press pulse and (optionally) an auto-repeat FSM.
//               Auto-repeat is built only when KEY_INPUT_AUTOREPEAT_EN is
//               defined; otherwise key_repeat is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_channel
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = c_DEBOUNCE_CYC_DEF,
    parameter int unsigned DAS_CYC      = c_DAS_CYC_DEF,
    parameter int unsigned ARR_CYC      = c_ARR_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_repeat
);

    localparam int unsigned      c_DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYC);

    logic              r_sync1;
    logic              r_sync2;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_level;
    logic              r_press;

    logic w_differ;
    logic w_db_done;
    logic w_level_nxt;
    logic w_rise;

    // Bring the asynchronous key into the clk domain; nothing else sees key_raw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Level flips when the input still differs while the counter holds the
    // full debounce count, so a raw edge shows up 2+DEBOUNCE_CYC edges later
    always_comb begin
        w_differ    = (r_sync2 != r_level);
        w_db_done   = w_differ && (r_db_cnt == c_DB_MAX);
        w_level_nxt = r_level ^ w_db_done;
        w_rise      = w_db_done && !r_level;
    end

    // Debounce counter: clears on agreement or on a level change, saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
        end else if (!w_differ || w_db_done) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt != c_DB_MAX) begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Registered stable level and one-cycle press pulse (rising edge only)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_press <= w_rise;
        end
    end

    assign key_level = r_level;
    assign key_press = r_press;

`ifdef KEY_INPUT_AUTOREPEAT_EN

    localparam int unsigned       c_RPT_MAX  = max_cyc(DAS_CYC, ARR_CYC);
    localparam int unsigned       c_RPT_W    = $clog2(c_RPT_MAX + 1);
    localparam logic [c_RPT_W-1:0] c_RPT_SAT  = c_RPT_W'(c_RPT_MAX);
    localparam logic [c_RPT_W-1:0] c_DAS_LAST = c_RPT_W'(DAS_CYC - 1);
    localparam logic [c_RPT_W-1:0] c_ARR_LAST = c_RPT_W'(ARR_CYC - 1);

    rpt_state_t         r_state;
    rpt_state_t         w_state_nxt;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic [c_RPT_W-1:0] w_rpt_cnt_nxt;
    logic [c_RPT_W-1:0] w_rpt_cnt_inc;
    logic               r_repeat;
    logic               w_repeat_nxt;

    // Repeat FSM next state; the next level is used so a release kills any
    // pulse in the very cycle key_level falls
    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_inc = (r_rpt_cnt == c_RPT_SAT) ? r_rpt_cnt : r_rpt_cnt + 1'b1;
        w_rpt_cnt_nxt = w_rpt_cnt_inc;
        w_repeat_nxt  = 1'b0;
        if (!w_level_nxt) begin
            w_state_nxt   = IDLE;
            w_rpt_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_rpt_cnt_nxt = '0;
                    if (w_rise) begin
                        w_state_nxt = DELAY;
                    end
                end
                DELAY: begin
                    if (r_rpt_cnt == c_DAS_LAST) begin
                        w_repeat_nxt  = 1'b1;
                        w_state_nxt   = REPEAT;
                        w_rpt_cnt_nxt = '0;
                    end
                end
                REPEAT: begin
                    if (r_rpt_cnt == c_ARR_LAST) begin
                        w_repeat_nxt  = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_rpt_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Repeat FSM state, shared counter and registered pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    assign key_repeat = r_repeat;

`else

    // Repeat timing is irrelevant without auto-repeat; fold it into a dead net
    logic w_unused_rpt_cfg;
    assign w_unused_rpt_cfg = (DAS_CYC > 0) ^ (ARR_CYC > 0);

    assign key_repeat = 1'b0;

`endif

endmodule : key_channel

`default_nettype wire

// File: rtl/key_input.sv
// ============================================================================
// Module      : key_input
// Description : NUM_KEYS independent debounced key channels with press pulses
//               and optional auto-repeat (macro KEY_INPUT_AUTOREPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_input
    import key_input_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = c_NUM_KEYS_DEF,
    parameter int unsigned DEBOUNCE_CYC = c_DEBOUNCE_CYC_DEF,
    parameter int unsigned DAS_CYC      = c_DAS_CYC_DEF,
    parameter int unsigned ARR_CYC      = c_ARR_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_repeat
);

    // One fully independent channel per key
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .DAS_CYC      (DAS_CYC),
            .ARR_CYC      (ARR_CYC)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_raw    (key_raw[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_repeat (key_repeat[i])
        );
    end

endmodule : key_input

`default_nettype wire

// File: doc/key_input.md
KEY_INPUT -- requirements
Module: key_input

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 1000000: consecutive clk cycles a synchronized input must differ from the stable level before the level changes; legal range >=1.
REQ-003 SHALL have parameter DAS_CYC, default 50000000: clk cycles from press to first auto-repeat pulse; legal range >=1.
REQ-004 SHALL have parameter ARR_CYC, default 10000000: clk cycles between later auto-repeat pulses; legal range >=1.
REQ-005 SHALL have port clk, input, 1: single system clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port key_raw, input, NUM_KEYS: asynchronous active-high raw key inputs; board inversion is done outside.
REQ-008 SHALL have port key_level, output, NUM_KEYS: debounced stable key state.
REQ-009 SHALL have port key_press, output, NUM_KEYS: one-cycle pulse per debounced rising edge.
REQ-010 SHALL have port key_repeat, output, NUM_KEYS: one-cycle auto-repeat pulses while a key is held.

Function
REQ-011 SHALL pass each key_raw bit through a 2-flop synchronizer; no other logic SHALL read key_raw.
REQ-012 SHALL keep one debounce counter per key, cleared in any cycle where the synchronized input equals key_level.
REQ-013 SHALL increment the counter each cycle the synchronized input differs from key_level; on the cycle it reaches DEBOUNCE_CYC, key_level SHALL toggle and the counter SHALL clear.
REQ-014 Latency: a clean raw edge sampled at cycle 0 SHALL change key_level at cycle 2+DEBOUNCE_CYC.
REQ-015 A glitch shorter than DEBOUNCE_CYC synchronized cycles SHALL produce no change on any output.
REQ-016 key_press SHALL be high in exactly the first cycle key_level reads 1 after reading 0; falling edges SHALL produce no pulse.
REQ-017 Each key SHALL run a repeat FSM with states IDLE, DELAY and REPEAT and one shared-width cycle counter.
REQ-018 IDLE->DELAY SHALL occur on the key_press cycle, with the counter cleared.
REQ-019 In DELAY, key_repeat SHALL pulse DAS_CYC cycles after the key_press cycle, and the FSM SHALL then enter REPEAT with the counter cleared.
REQ-020 In REPEAT, key_repeat SHALL pulse every ARR_CYC cycles.
REQ-021 In any state, key_level=0 SHALL force IDLE the same cycle; no key_repeat pulse SHALL occur in or after the cycle key_level falls.
REQ-022 Counter widths SHALL be $clog2(max+1) of their limit; counters SHALL saturate, never wrap.
REQ-023 Channels SHALL be fully independent; simultaneous presses on several keys SHALL each produce their own pulses in the same cycle.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst_n low SHALL asynchronously clear synchronizers, counters and key_level, set FSMs to IDLE, and drive key_level, key_press and key_repeat to 0.
REQ-026 A key held through reset release SHALL be treated as a new press, giving key_press at cycle 2+DEBOUNCE_CYC after the first clk edge with rst_n high.
REQ-027 Reset mid-debounce or mid-repeat SHALL discard all progress, with no pulse in the reset cycle.

Configuration
REQ-028 Macro KEY_INPUT_AUTOREPEAT_EN defined: repeat FSM and counters SHALL be built as specified.
REQ-029 Macro KEY_INPUT_AUTOREPEAT_EN undefined: key_repeat SHALL be constant 0, no repeat logic SHALL be synthesized, and DAS_CYC/ARR_CYC SHALL be ignored.

Structure
REQ-030 Package key_input_pkg SHALL hold the repeat-state enum (IDLE, DELAY, REPEAT) and default cycle constants.
REQ-031 Sub-module key_channel SHALL implement one key (synchronizer, debounce, edge detect, repeat FSM); key_input SHALL instantiate NUM_KEYS copies via generate.

Verification
(Bench parameters: DEBOUNCE_CYC=4, DAS_CYC=10, ARR_CYC=3, NUM_KEYS=4.)
REQ-032 Reset release with all keys low: key_raw=0 -> all outputs 0 for 100 cycles.
REQ-033 Glitch: key_raw[0] high for 3 cycles -> key_level, key_press and key_repeat stay 0.
REQ-034 Clean press: key_raw[1] rises at cycle 0 -> key_level[1]=1 and a single key_press[1] pulse at cycle 6, with no pulse on release.
REQ-035 Hold key 2 for 40 cycles after press -> key_repeat[2] pulses at press+10, +13, +16 and so on, and stops at the cycle key_level[2] falls.
REQ-036 Simultaneous: keys 0 and 3 rise together -> same-cycle key_press pulses; rst_n pulsed mid-DELAY -> outputs 0, with a new key_press at cycle 6 after release.
REQ-037 With KEY_INPUT_AUTOREPEAT_EN undefined, scenario REQ-035 -> key_repeat stays 0 throughout.
